// File: rtl/amm_master_pkg.sv
// Shared types and default constants for the switch-driven Avalon-MM master.
package amm_master_pkg;

  localparam int unsigned AddrWidthDef      = 28;
  localparam int unsigned DataWidthDef      = 32;
  localparam int unsigned DebounceCyclesDef = 50000;
  localparam int unsigned RdTimeoutDef      = 1024;

  // Board switch field positions (SW[17:0])
  localparam int unsigned SwRdwrCntlBit   = 17;
  localparam int unsigned SwAddDataSelBit = 16;
  localparam int unsigned SwDataMsb       = 15;
  localparam int unsigned SwDataLsb       = 0;
  localparam int unsigned SwDataWidth     = SwDataMsb - SwDataLsb + 1;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StRdWait
  } state_e;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus level debouncer for an active-low push button;
// emits a one-cycle press pulse on each accepted 1-to-0 transition.
module key_debounce
  import amm_master_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDef
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;
  logic            key_s;

  assign key_s = sync_q[1];

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (key_s != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = key_s;
        press_d = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/amm_switch_master.sv
// Avalon-MM master driven by board switches and a push button: loads a word
// address, then performs single writes or pipelined reads shown on the HEX display.
module amm_switch_master
  import amm_master_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH    = AddrWidthDef,
  parameter int unsigned DATAWIDTH       = DataWidthDef,
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDef,
  parameter int unsigned RD_TIMEOUT      = RdTimeoutDef
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rdwr_cntl,
  input  logic                    n_action,
  input  logic                    add_data_sel,
  input  logic [SwDataWidth-1:0]  rdwr_address,
  output logic [ADDRESSWIDTH-1:0] avm_address,
  output logic                    avm_read,
  output logic                    avm_write,
  output logic [DATAWIDTH-1:0]    avm_writedata,
  output logic [DATAWIDTH/8-1:0]  avm_byteenable,
  input  logic                    avm_waitrequest,
  input  logic [DATAWIDTH-1:0]    avm_readdata,
  input  logic                    avm_readdatavalid,
  output logic [31:0]             display_data,
  output logic                    busy,
  output logic                    rd_timeout_err
);

  localparam int unsigned TmoW = $clog2(RD_TIMEOUT + 1);

  logic                   press;
  state_e                 state_q, state_d;
  logic [SwDataWidth-1:0] addr_q, addr_d;
  logic [SwDataWidth-1:0] wdata_q, wdata_d;
  logic [31:0]            disp_q, disp_d;
  logic                   err_q, err_d;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic [31:0]            rdata32;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .key_n  (n_action),
    .press  (press)
  );

  assign rdata32 = 32'(avm_readdata);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    disp_d  = disp_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        // Presses in any other state are dropped, never queued.
        if (press) begin
          if (add_data_sel) begin
            addr_d = rdwr_address;
            disp_d = 32'(rdwr_address);
          end else if (rdwr_cntl) begin
            wdata_d = rdwr_address;
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StWrite: begin
        if (!avm_waitrequest) begin
          disp_d  = 32'(wdata_q);
          state_d = StIdle;
        end
      end
      StRead: begin
        if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            disp_d  = rdata32;
            err_d   = 1'b0;
            state_d = StIdle;
          end else begin
            tmo_d   = '0;
            state_d = StRdWait;
          end
        end
      end
      StRdWait: begin
        if (avm_readdatavalid) begin
          disp_d  = rdata32;
          err_d   = 1'b0;
          state_d = StIdle;
        end else if (tmo_q == TmoW'(RD_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      disp_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Commands decode straight from the state register so reset clears them at once.
  assign avm_write      = (state_q == StWrite);
  assign avm_read       = (state_q == StRead);
  assign avm_address    = ADDRESSWIDTH'({addr_q, 2'b00});
  assign avm_writedata  = DATAWIDTH'(wdata_q);
  assign avm_byteenable = '1;
  assign display_data   = disp_q;
  assign busy           = (state_q != StIdle);
  assign rd_timeout_err = err_q;

endmodule

// File: tb/tb_amm_switch_master.sv
// Randomized scoreboard bench for amm_switch_master with a small Avalon slave model.
module tb_amm_switch_master;

  localparam int unsigned DEB  = 8;
  localparam int unsigned TMO  = 16;
  localparam int unsigned HOLD = DEB + 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rdwr_cntl = 1'b0;
  logic        n_action = 1'b1;
  logic        add_data_sel = 1'b0;
  logic [15:0] rdwr_address = 16'h0;
  logic [27:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b1;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] display_data;
  logic        busy, rd_timeout_err;

  always #5 clk = ~clk;

  amm_switch_master #(
    .ADDRESSWIDTH   (28),
    .DATAWIDTH      (32),
    .DEBOUNCE_CYCLES(DEB),
    .RD_TIMEOUT     (TMO)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .rdwr_cntl        (rdwr_cntl),
    .n_action         (n_action),
    .add_data_sel     (add_data_sel),
    .rdwr_address     (rdwr_address),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .display_data     (display_data),
    .busy             (busy),
    .rd_timeout_err   (rd_timeout_err)
  );

  typedef struct {
    logic [31:0] disp;
    logic        err;
    logic [27:0] addr;
    int          cmd;  // cycles with avm_read/avm_write high
    int          rdw;  // busy cycles with no command (waiting for read data)
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   press_cnt = 0;

  // Reference model state
  logic [31:0] m_disp = 32'h0;
  logic        m_err = 1'b0;
  logic [15:0] m_addr = 16'h0;
  logic [15:0] cur_wdata = 16'h0;

  // Slave configuration for the current transaction
  int          s_wait = 0;
  int          s_lat = 0;
  logic [31:0] s_rdata = 32'h0;
  bit          s_nordv = 1'b0;
  bit          s_late = 1'b0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // Avalon slave: stalls each command s_wait cycles, returns data s_lat cycles later.
  initial begin
    int wcnt = 0;
    int pend = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        wcnt = 0;
        pend = 0;
        avm_waitrequest = 1'b1;
        avm_readdatavalid = 1'b0;
      end else begin
        avm_readdatavalid = 1'b0;
        if (s_late) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = 32'hDEAD_BEEF;
          s_late = 1'b0;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = s_rdata;
          end
        end
        if (avm_write || avm_read) begin
          if (wcnt < s_wait) begin
            avm_waitrequest = 1'b1;
            wcnt++;
          end else begin
            avm_waitrequest = 1'b0;
            wcnt = 0;
            if (avm_read && !s_nordv) begin
              if (s_lat == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = s_rdata;
              end else begin
                pend = s_lat;
              end
            end
          end
        end else begin
          avm_waitrequest = 1'b1;
          wcnt = 0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    if (dut.press) press_cnt++;
  end

  // Monitor: pops an expectation whenever a transfer completes or a visible output changes.
  initial begin
    logic        prev_busy = 1'b0;
    logic [31:0] prev_disp = 32'h0;
    logic        prev_err = 1'b0;
    int          cmd_cnt = 0;
    int          rdw_cnt = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("rd_wr_exclusive", 64'(avm_read & avm_write), 64'd0);
        if (avm_write) begin
          check("wr_data", 64'(avm_writedata), 64'({16'h0, cur_wdata}));
          check("wr_addr", 64'(avm_address), 64'({m_addr, 2'b00}));
        end
        if (avm_read || avm_write) cmd_cnt++;
        else if (busy) rdw_cnt++;
        if ((prev_busy && !busy) || display_data != prev_disp || rd_timeout_err != prev_err) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: display %h err %b busy %b, no transfer outstanding",
                     display_data, rd_timeout_err, busy);
          end else begin
            e = exp_q.pop_front();
            check("display_data", 64'(display_data), 64'(e.disp));
            check("rd_timeout_err", 64'(rd_timeout_err), 64'(e.err));
            check("avm_address", 64'(avm_address), 64'(e.addr));
            check("cmd_cycles", 64'(cmd_cnt), 64'(e.cmd));
            check("rdwait_cycles", 64'(rdw_cnt), 64'(e.rdw));
          end
          cmd_cnt = 0;
          rdw_cnt = 0;
        end
      end else begin
        cmd_cnt = 0;
        rdw_cnt = 0;
      end
      prev_busy = busy;
      prev_disp = display_data;
      prev_err  = rd_timeout_err;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_wait: busy still 1 after 300 cycles, required 0");
    end
  endtask

  task automatic press_key(input bit bounce);
    if (bounce) begin
      for (int i = 0; i < 10; i++) begin
        n_action = ~n_action;
        cyc(3);
      end
    end
    n_action = 1'b0;
    cyc(HOLD);
    // Inputs after the press must not disturb a transfer already started.
    rdwr_address = ~rdwr_address;
    rdwr_cntl = ~rdwr_cntl;
    n_action = 1'b1;
    cyc(HOLD);
  endtask

  // kind: 0 = load address, 1 = write, 2 = read, 3 = read with no data (timeout)
  task automatic op(input int kind, input logic [15:0] sw, input int wt, input int lat,
                    input logic [31:0] rd, input bit bounce);
    exp_t e;
    wait_idle();
    @(negedge clk);
    add_data_sel = (kind == 0);
    rdwr_cntl = (kind == 0) ? 1'($urandom_range(0, 1)) : (kind == 1);
    rdwr_address = sw;
    s_wait = wt;
    s_lat = lat;
    s_rdata = rd;
    s_nordv = (kind == 3);
    e.cmd = wt + 1;
    e.rdw = 0;
    case (kind)
      0: begin
        m_addr = sw;
        m_disp = {16'h0, sw};
        e.cmd = 0;
      end
      1: begin
        cur_wdata = sw;
        m_disp = {16'h0, sw};
      end
      2: begin
        m_disp = rd;
        m_err = 1'b0;
        e.rdw = lat;
      end
      default: begin
        m_err = 1'b1;
        e.rdw = TMO;
      end
    endcase
    e.disp = m_disp;
    e.err = m_err;
    e.addr = {10'h0, m_addr, 2'b00};
    exp_q.push_back(e);
    press_key(bounce);
    wait_idle();
    cyc(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc0;
    int k;
    int kind;
    logic [15:0] sw;

    cyc(3);
    check("reset_avm_write", 64'(avm_write), 64'd0);
    check("reset_avm_read", 64'(avm_read), 64'd0);
    check("reset_display", 64'(display_data), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_err", 64'(rd_timeout_err), 64'd0);
    check("reset_address", 64'(avm_address), 64'd0);
    check("byteenable", 64'(avm_byteenable), 64'hF);
    reset_n = 1'b1;
    cyc(3);

    op(0, 16'h0010, 0, 0, 32'h0, 1'b0);
    check("addr_load_address", 64'(avm_address), 64'h0000040);
    check("addr_load_display", 64'(display_data), 64'h00000010);
    op(1, 16'hBEEF, 3, 0, 32'h0, 1'b0);
    check("write_display", 64'(display_data), 64'h0000BEEF);
    op(2, 16'h0000, 0, 5, 32'hCAFEF00D, 1'b0);
    check("read_display", 64'(display_data), 64'hCAFEF00D);
    op(3, 16'h0000, 1, 0, 32'h0, 1'b0);
    check("timeout_flag", 64'(rd_timeout_err), 64'd1);
    check("timeout_display", 64'(display_data), 64'hCAFEF00D);
    op(2, 16'h0000, 2, 0, 32'h1234_5678, 1'b0);
    check("err_cleared", 64'(rd_timeout_err), 64'd0);

    pc0 = press_cnt;
    op(0, 16'h0A0B, 0, 0, 32'h0, 1'b1);
    check("bounce_press_count", 64'(press_cnt - pc0), 64'd1);

    // Reset asserted while a write is stalled.
    wait_idle();
    @(negedge clk);
    add_data_sel = 1'b0;
    rdwr_cntl = 1'b1;
    rdwr_address = 16'h5A5A;
    cur_wdata = 16'h5A5A;
    s_wait = 100;
    n_action = 1'b0;
    k = 0;
    while (!avm_write && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("midwrite_started", 64'(avm_write), 64'd1);
    #2;
    reset_n = 1'b0;
    m_disp = 32'h0;
    m_err = 1'b0;
    m_addr = 16'h0;
    #1;
    check("async_reset_write", 64'(avm_write), 64'd0);
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_display", 64'(display_data), 64'(m_disp));
    check("async_reset_wdata", 64'(avm_writedata), 64'd0);
    check("async_reset_address", 64'(avm_address), 64'd0);
    n_action = 1'b1;
    cyc(3);
    reset_n = 1'b1;
    cyc(HOLD);
    s_late = 1'b1;
    cyc(4);
    check("late_rdv_ignored", 64'(display_data), 64'(m_disp));
    op(1, 16'h1357, 1, 0, 32'h0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      sw = 16'($urandom);
      if (kind == 0) begin
        while ({16'h0, sw} == m_disp) sw = sw + 16'd1;
      end
      op(kind, sw, $urandom_range(0, 3), $urandom_range(0, 5), $urandom, 1'b0);
    end

    cyc(10);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
